// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory: P has fixed priority, D is served after at most MAX_WAIT blocked cycles.
// Optional build macro DMEM_ARB_STATS_EN adds a saturating conflict_cnt output.
module dmem_arbiter #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 8,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p_req,
    input  logic              p_we,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic [DATA_W-1:0] p_wdata,
    output logic              p_gnt,
    output logic              p_rvalid,
    output logic [DATA_W-1:0] p_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0]       conflict_cnt
`endif
);

    localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

    logic [3:0] r_wait_cnt;
    logic       r_rd_pend;
    logic       r_rd_src;
    logic       w_d_win;

    // D wins when P is idle, or when D has already waited its full allowance.
    assign w_d_win = d_req && (!p_req || (r_wait_cnt == MAX_W));

    always_comb begin
        p_gnt = rst_n && p_req && !w_d_win;
        d_gnt = rst_n && w_d_win;
    end

    always_comb begin
        mem_en    = p_gnt | d_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (d_gnt) begin
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end else if (p_gnt) begin
            mem_we    = p_we;
            mem_addr  = p_addr;
            mem_wdata = p_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wait_cnt <= 4'd0;
        end else if (!d_req || d_gnt) begin
            r_wait_cnt <= 4'd0;
        end else if (r_wait_cnt != MAX_W) begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
        end
    end

    // Remember who issued the read so the 1-cycle-late data goes back to it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_pend <= 1'b0;
            r_rd_src  <= 1'b0;
        end else begin
            r_rd_pend <= (p_gnt && !p_we) || (d_gnt && !d_we);
            r_rd_src  <= d_gnt;
        end
    end

    always_comb begin
        p_rvalid = r_rd_pend && !r_rd_src;
        d_rvalid = r_rd_pend && r_rd_src;
        p_rdata  = p_rvalid ? mem_rdata : '0;
        d_rdata  = d_rvalid ? mem_rdata : '0;
    end

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] r_conflict_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_conflict_cnt <= 16'd0;
        end else if (p_req && d_req && (r_conflict_cnt != 16'hFFFF)) begin
            r_conflict_cnt <= r_conflict_cnt + 16'd1;
        end
    end

    assign conflict_cnt = r_conflict_cnt;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural 1-cycle memory, read-data scoreboard per port, one task per scenario.
module tb_dmem_arbiter;
    localparam int AW = 5;
    localparam int DW = 8;
    localparam int MW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          p_req, p_we, d_req, d_we;
    logic [AW-1:0] p_addr, d_addr, mem_addr;
    logic [DW-1:0] p_wdata, d_wdata, mem_wdata, mem_rdata;
    logic          p_gnt, p_rvalid, d_gnt, d_rvalid, mem_en, mem_we;
    logic [DW-1:0] p_rdata, d_rdata;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0]   conflict_cnt;
`endif

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst_n(rst_n),
        .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_gnt(p_gnt), .p_rvalid(p_rvalid), .p_rdata(p_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_STATS_EN
        , .conflict_cnt(conflict_cnt)
`endif
    );

    logic [DW-1:0] mem [32] = '{default: 8'h00};
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          pq[$];
    exp_t          dq[$];
    logic [DW-1:0] shadow [32];
    int            n_vec = 0;
    int            n_err = 0;
    int            cyc   = 0;

    task automatic drive(input logic pr, input logic pw, input logic [AW-1:0] pa, input logic [DW-1:0] pd,
                         input logic dr, input logic dw, input logic [AW-1:0] da, input logic [DW-1:0] dd);
        p_req = pr; p_we = pw; p_addr = pa; p_wdata = pd;
        d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
    endtask

    task automatic push_p(input logic [AW-1:0] a);
        exp_t e;
        e.due = cyc + 1; e.data = shadow[a];
        pq.push_back(e);
    endtask

    task automatic push_d(input logic [AW-1:0] a);
        exp_t e;
        e.due = cyc + 1; e.data = shadow[a];
        dq.push_back(e);
    endtask

    // Pops the read-data scoreboard in the cycle each rvalid is due.
    task automatic sb_check();
        logic ev;
        ev = (pq.size() > 0) && (pq[0].due == cyc);
        n_vec++;
        if (p_rvalid !== ev) begin
            n_err++; $display("FAIL p_rvalid cyc=%0d got=%b expected=%b", cyc, p_rvalid, ev);
        end
        n_vec++;
        if (ev) begin
            if (p_rdata !== pq[0].data) begin
                n_err++; $display("FAIL p_rdata cyc=%0d got=%0d expected=%0d", cyc, $signed(p_rdata), $signed(pq[0].data));
            end
            void'(pq.pop_front());
        end else if (p_rdata !== 8'h00) begin
            n_err++; $display("FAIL p_rdata_idle cyc=%0d got=%h expected=00", cyc, p_rdata);
        end
        ev = (dq.size() > 0) && (dq[0].due == cyc);
        n_vec++;
        if (d_rvalid !== ev) begin
            n_err++; $display("FAIL d_rvalid cyc=%0d got=%b expected=%b", cyc, d_rvalid, ev);
        end
        n_vec++;
        if (ev) begin
            if (d_rdata !== dq[0].data) begin
                n_err++; $display("FAIL d_rdata cyc=%0d got=%0d expected=%0d", cyc, $signed(d_rdata), $signed(dq[0].data));
            end
            void'(dq.pop_front());
        end else if (d_rdata !== 8'h00) begin
            n_err++; $display("FAIL d_rdata_idle cyc=%0d got=%h expected=00", cyc, d_rdata);
        end
    endtask

    task automatic settle();
        @(negedge clk);
        sb_check();
    endtask

    task automatic next();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        next();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1, 0, 5'd0, 0, 1, 0, 5'd0, 0);
        repeat (2) begin
            settle();
            n_vec++;
            if ({p_gnt, d_gnt, mem_en, mem_we} !== 4'b0000) begin
                n_err++; $display("FAIL reset_outputs p/d_gnt,en,we got=%b expected=0000", {p_gnt, d_gnt, mem_en, mem_we});
            end
            next();
        end
        rst_n = 1'b1;
        settle();
        n_vec++;
        if ({p_gnt, d_gnt, mem_en} !== 3'b101) begin
            n_err++; $display("FAIL reset_release p_gnt,d_gnt,en got=%b expected=101", {p_gnt, d_gnt, mem_en});
        end
        push_p(5'd0);
        next();
        idle_cycle();
        $display("reset: %0d vectors so far", n_vec);
    endtask

    task automatic test_p_write_read();
        drive(1, 1, 5'd3, 8'hF9, 0, 0, 0, 0);
        settle();
        n_vec++;
        if ({p_gnt, d_gnt, mem_en, mem_we} !== 4'b1011 || mem_addr !== 5'd3 || mem_wdata !== 8'hF9) begin
            n_err++; $display("FAIL p_write gnt/en/we=%b addr=%0d wdata=%h expected 1011/3/f9",
                              {p_gnt, d_gnt, mem_en, mem_we}, mem_addr, mem_wdata);
        end
        shadow[3] = 8'hF9;
        next();
        drive(1, 0, 5'd3, 0, 0, 0, 0, 0);
        settle();
        n_vec++;
        if ({p_gnt, mem_en, mem_we} !== 3'b110 || mem_addr !== 5'd3) begin
            n_err++; $display("FAIL p_read gnt/en/we=%b addr=%0d expected 110/3", {p_gnt, mem_en, mem_we}, mem_addr);
        end
        push_p(5'd3);
        next();
        idle_cycle();
        $display("p_write_read: wrote -7 to addr 3 and read it back");
    endtask

    task automatic test_preload();
        for (int i = 1; i <= 2; i++) begin
            drive(0, 0, 0, 0, 1, 1, 5'(i), 8'(i * 10));
            settle();
            n_vec++;
            if ({p_gnt, d_gnt, mem_we} !== 3'b011 || mem_addr !== 5'(i) || mem_wdata !== 8'(i * 10)) begin
                n_err++; $display("FAIL d_write gnt/we=%b addr=%0d wdata=%0d expected 011/%0d/%0d",
                                  {p_gnt, d_gnt, mem_we}, mem_addr, mem_wdata, i, i * 10);
            end
            shadow[i] = 8'(i * 10);
            next();
        end
        $display("preload: D wrote addr1=10 addr2=20");
    endtask

    task automatic test_interleave();
        drive(1, 0, 5'd1, 0, 0, 0, 0, 0);
        settle();
        n_vec++;
        if ({p_gnt, d_gnt} !== 2'b10 || mem_addr !== 5'd1) begin
            n_err++; $display("FAIL inter_p gnt=%b addr=%0d expected 10/1", {p_gnt, d_gnt}, mem_addr);
        end
        push_p(5'd1);
        next();
        drive(0, 0, 0, 0, 1, 0, 5'd2, 0);
        settle();
        n_vec++;
        if ({p_gnt, d_gnt} !== 2'b01 || mem_addr !== 5'd2) begin
            n_err++; $display("FAIL inter_d gnt=%b addr=%0d expected 01/2", {p_gnt, d_gnt}, mem_addr);
        end
        push_d(5'd2);
        next();
        idle_cycle();
        $display("interleave: P read addr1 then D read addr2");
    endtask

    // Both ports held requesting: D must win exactly on its (MW+1)-th cycle.
    task automatic contend(input int ncyc, input logic [AW-1:0] pa, input string tag);
        logic exp_d;
        for (int k = 0; k < ncyc; k++) begin
            drive(1, 1, pa, 8'(k + 1), 1, 0, 5'd2, 0);
            settle();
            exp_d = (k == MW);
            n_vec++;
            if (p_gnt !== !exp_d || d_gnt !== exp_d || mem_addr !== (exp_d ? 5'd2 : pa)) begin
                n_err++; $display("FAIL %s k=%0d p_gnt=%b d_gnt=%b addr=%0d expected %b/%b/%0d",
                                  tag, k, p_gnt, d_gnt, mem_addr, !exp_d, exp_d, exp_d ? 2 : pa);
            end
            if (exp_d) push_d(5'd2);
            else       shadow[pa] = 8'(k + 1);
            next();
        end
    endtask

    task automatic test_starvation();
        contend(6, 5'd7, "starve");
        idle_cycle();
        $display("starvation: P 0-3, D 4, P 5");
    endtask

    task automatic test_withdraw();
        for (int k = 0; k < 2; k++) begin
            drive(1, 1, 5'd8, 8'h11, 1, 0, 5'd1, 0);
            settle();
            n_vec++;
            if ({p_gnt, d_gnt} !== 2'b10) begin
                n_err++; $display("FAIL withdraw_pre k=%0d gnt=%b expected 10", k, {p_gnt, d_gnt});
            end
            shadow[8] = 8'h11;
            next();
        end
        drive(1, 1, 5'd8, 8'h12, 0, 0, 0, 0);
        settle();
        n_vec++;
        if ({p_gnt, d_gnt} !== 2'b10) begin
            n_err++; $display("FAIL withdraw_drop gnt=%b expected 10", {p_gnt, d_gnt});
        end
        shadow[8] = 8'h12;
        next();
        contend(5, 5'd8, "withdraw_restart");
        idle_cycle();
        $display("withdraw: D dropped request, wait restarted from zero");
    endtask

    task automatic test_back_to_back();
        logic          we_t [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [AW-1:0] ad_t [6] = '{5'd9, 5'd9, 5'd1, 5'd3, 5'd2, 5'd7};
        for (int k = 0; k < 6; k++) begin
            drive(1, we_t[k], ad_t[k], 8'h55, 0, 0, 0, 0);
            settle();
            n_vec++;
            if (p_gnt !== 1'b1 || mem_we !== we_t[k] || mem_addr !== ad_t[k]) begin
                n_err++; $display("FAIL b2b k=%0d gnt=%b we=%b addr=%0d expected 1/%b/%0d",
                                  k, p_gnt, mem_we, mem_addr, we_t[k], ad_t[k]);
            end
            if (we_t[k]) shadow[ad_t[k]] = 8'h55;
            else         push_p(ad_t[k]);
            next();
        end
        idle_cycle();
        $display("back_to_back: write-then-read addr9 plus 4 chained reads");
    endtask

    task automatic test_reset_mid_read();
        drive(0, 0, 0, 0, 1, 0, 5'd2, 0);
        settle();
        n_vec++;
        if (d_gnt !== 1'b1) begin
            n_err++; $display("FAIL midrd_gnt got=%b expected=1", d_gnt);
        end
        #2 rst_n = 1'b0;
        next();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        next();
        rst_n = 1'b1;
        settle();
        next();
        settle();
        next();
        $display("reset_mid_read: pending D read dropped");
    endtask

`ifdef DMEM_ARB_STATS_EN
    task automatic test_stats();
        rst_n = 1'b0;
        drive(1, 1, 5'd10, 0, 1, 0, 5'd2, 0);
        settle();
        next();
        rst_n = 1'b1;
        contend(6, 5'd10, "stats");
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        n_vec++;
        if (conflict_cnt !== 16'd6) begin
            n_err++; $display("FAIL conflict_cnt got=%0d expected=6", conflict_cnt);
        end
        next();
        $display("stats: conflict_cnt after 6 conflict cycles");
    endtask
`endif

    initial begin
        for (int i = 0; i < 32; i++) shadow[i] = 8'h00;
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        test_reset();
        test_p_write_read();
        test_preload();
        test_interleave();
        test_starvation();
        test_withdraw();
        test_back_to_back();
        test_reset_mid_read();
`ifdef DMEM_ARB_STATS_EN
        test_stats();
`endif
        n_vec++;
        if (pq.size() != 0 || dq.size() != 0) begin
            n_err++; $display("FAIL scoreboard_drain p_left=%0d d_left=%0d expected 0/0", pq.size(), dq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
